// File: rtl/fpu_pkg.sv
// Shared FPU types and format constants for the operand converter and the adder.
package fpu_pkg;

    localparam int EXP_W       = 10;
    localparam int FRAC_W      = 21;
    localparam int BIAS_INT    = 511;
    localparam int BIAS_DELTA  = 384;
    localparam int EXP_SPECIAL = 1023;
    localparam logic [FRAC_W-1:0] QNAN_FRAC = 21'h100000;

    typedef enum logic [1:0] {
        EXACT     = 2'd0,
        INEXACT   = 2'd1,
        OVERFLOW  = 2'd2,
        UNDERFLOW = 2'd3
    } status_t;

    typedef enum logic [2:0] {
        CV_IDLE      = 3'd0,
        CV_CLASSIFY  = 3'd1,
        CV_NORMALIZE = 3'd2,
        CV_ROUND     = 3'd3,
        CV_OUTPUT    = 3'd4
    } cv_state_t;

endpackage

// File: rtl/fpu_rne_round.sv
// Round-to-nearest-even of a normalised 24-bit mantissa down to the 21-bit internal fraction.
module fpu_rne_round
    import fpu_pkg::*;
(
    input  logic [23:0]       i_mant,
    input  logic [EXP_W-1:0]  i_exp,
    output logic [FRAC_W-1:0] o_frac,
    output logic [EXP_W-1:0]  o_exp,
    output logic              o_inexact
);

    logic        w_guard;
    logic        w_sticky;
    logic        w_inc;
    logic [22:0] w_sum;

    assign w_guard  = i_mant[1];
    assign w_sticky = i_mant[0];
    assign w_inc    = w_guard & (w_sticky | i_mant[2]);

    // Hidden bit is always 1 here, so a carry out of the fraction lands in w_sum[22].
    assign w_sum     = {1'b0, i_mant[23:2]} + {22'd0, w_inc};
    assign o_frac    = w_sum[FRAC_W-1:0];
    assign o_exp     = i_exp + {{(EXP_W-1){1'b0}}, w_sum[22]};
    assign o_inexact = w_guard | w_sticky;

endmodule

// File: rtl/fpu_operand_converter.sv
// Converts an IEEE-754 single operand pair into the adder's internal format, one operand at a time.
module fpu_operand_converter
    import fpu_pkg::*;
(
    input  logic        clock_100Khz,
    input  logic        reset,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_ieee_a,
    input  logic [31:0] i_ieee_b,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_op_a_out,
    output logic [31:0] o_op_b_out,
    output status_t     o_status_a,
    output status_t     o_status_b
);

    cv_state_t        r_state, w_state_next;
    logic             r_sel;
    logic [31:0]      r_ieee_a, r_ieee_b;
    logic [23:0]      r_mant;
    logic [EXP_W-1:0] r_exp;
    logic [31:0]      r_op_a, r_op_b;
    status_t          r_status_a, r_status_b;
    logic             r_out_valid;

    logic [31:0]       w_cur;
    logic              w_sgn;
    logic [7:0]        w_e;
    logic [22:0]       w_m;
    logic              w_zero, w_sub, w_spec, w_bypass;
    logic [FRAC_W-1:0] w_rnd_frac;
    logic [EXP_W-1:0]  w_rnd_exp;
    logic              w_rnd_inexact;
    logic              w_res_we;
    logic [31:0]       w_res;
    status_t           w_res_st;
    cv_state_t         w_after;

    assign w_cur    = r_sel ? r_ieee_b : r_ieee_a;
    assign w_sgn    = w_cur[31];
    assign w_e      = w_cur[30:23];
    assign w_m      = w_cur[22:0];
    assign w_zero   = (w_e == 8'd0) && (w_m == 23'd0);
    assign w_sub    = (w_e == 8'd0) && (w_m != 23'd0);
    assign w_spec   = (w_e == 8'hFF);
    assign w_bypass = w_zero | w_spec;
    assign w_after  = r_sel ? CV_OUTPUT : CV_CLASSIFY;

    fpu_rne_round u_round (
        .i_mant    (r_mant),
        .i_exp     (r_exp),
        .o_frac    (w_rnd_frac),
        .o_exp     (w_rnd_exp),
        .o_inexact (w_rnd_inexact)
    );

    always_comb begin
        w_res    = {r_sel ? r_ieee_b[31] : r_ieee_a[31], w_rnd_exp, w_rnd_frac};
        w_res_st = w_rnd_inexact ? INEXACT : EXACT;
        w_res_we = 1'b0;
        if (r_state == CV_CLASSIFY && w_bypass) begin
            w_res_we = 1'b1;
            if (w_zero) begin
                w_res    = {w_sgn, {EXP_W{1'b0}}, {FRAC_W{1'b0}}};
                w_res_st = EXACT;
            end else begin
                w_res    = {w_sgn, EXP_W'(EXP_SPECIAL), (w_m != 23'd0) ? QNAN_FRAC : {FRAC_W{1'b0}}};
                w_res_st = OVERFLOW;
            end
        end else if (r_state == CV_ROUND) begin
            w_res_we = 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CV_IDLE:      if (i_in_valid) w_state_next = CV_CLASSIFY;
            CV_CLASSIFY:  w_state_next = w_bypass ? w_after : (w_sub ? CV_NORMALIZE : CV_ROUND);
            CV_NORMALIZE: if (r_mant[23]) w_state_next = CV_ROUND;
            CV_ROUND:     w_state_next = w_after;
            CV_OUTPUT:    if (i_out_ready) w_state_next = CV_IDLE;
            default:      w_state_next = CV_IDLE;
        endcase
    end

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) r_state <= CV_IDLE;
        else        r_state <= w_state_next;
    end

    always_ff @(posedge clock_100Khz or negedge reset) begin
        if (!reset) begin
            r_sel       <= 1'b0;
            r_ieee_a    <= '0;
            r_ieee_b    <= '0;
            r_mant      <= '0;
            r_exp       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_status_a  <= EXACT;
            r_status_b  <= EXACT;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_state_next == CV_OUTPUT);
            if (r_state == CV_IDLE && i_in_valid) begin
                r_ieee_a <= i_ieee_a;
                r_ieee_b <= i_ieee_b;
                r_sel    <= 1'b0;
            end
            if (r_state == CV_CLASSIFY && !w_bypass) begin
                // Subnormals start at the minimum normal exponent and shift down from there.
                r_mant <= {~w_sub, w_m};
                r_exp  <= w_sub ? EXP_W'(BIAS_DELTA + 1) : ({2'b00, w_e} + EXP_W'(BIAS_DELTA));
            end
            if (r_state == CV_NORMALIZE && !r_mant[23]) begin
                r_mant <= {r_mant[22:0], 1'b0};
                r_exp  <= r_exp - 1'b1;
            end
            if (w_res_we) begin
                if (r_sel) begin
                    r_op_b     <= w_res;
                    r_status_b <= w_res_st;
                end else begin
                    r_op_a     <= w_res;
                    r_status_a <= w_res_st;
                    r_sel      <= 1'b1;
                end
            end
        end
    end

    assign o_in_ready  = (r_state == CV_IDLE);
    assign o_out_valid = r_out_valid;
    assign o_op_a_out  = r_op_a;
    assign o_op_b_out  = r_op_b;
    assign o_status_a  = r_status_a;
    assign o_status_b  = r_status_b;

endmodule

// File: tb/tb_fpu_operand_converter.sv
// Directed-vector bench for fpu_operand_converter with hand-computed expected results.
module tb_fpu_operand_converter;
    import fpu_pkg::*;

    logic        clock_100Khz;
    logic        reset;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [31:0] i_ieee_a;
    logic [31:0] i_ieee_b;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [31:0] o_op_a_out;
    logic [31:0] o_op_b_out;
    status_t     o_status_a;
    status_t     o_status_b;

    int total = 0;
    int npass = 0;

    fpu_operand_converter dut (
        .clock_100Khz (clock_100Khz),
        .reset        (reset),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_ieee_a     (i_ieee_a),
        .i_ieee_b     (i_ieee_b),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_op_a_out   (o_op_a_out),
        .o_op_b_out   (o_op_b_out),
        .o_status_a   (o_status_a),
        .o_status_b   (o_status_b)
    );

    initial clock_100Khz = 1'b0;
    always #5 clock_100Khz = ~clock_100Khz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic start_pair(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock_100Khz);
        i_in_valid = 1'b1;
        i_ieee_a   = a;
        i_ieee_b   = b;
        @(posedge clock_100Khz);
        #1;
        i_in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag, input int exp_n);
        int cyc = 0;
        while (!o_out_valid && cyc < 200) begin
            @(posedge clock_100Khz);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 32'(cyc), 32'(exp_n));
    endtask

    task automatic check_pair(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                              input status_t sa, input status_t sb);
        chk({tag, "_op_a"}, o_op_a_out, ea);
        chk({tag, "_op_b"}, o_op_b_out, eb);
        chk({tag, "_st_a"}, 32'(o_status_a), 32'(sa));
        chk({tag, "_st_b"}, 32'(o_status_b), 32'(sb));
    endtask

    task automatic accept(input string tag);
        @(negedge clock_100Khz);
        i_out_ready = 1'b1;
        @(posedge clock_100Khz);
        #1;
        i_out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(o_out_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(o_in_ready), 32'd1);
    endtask

    initial begin
        reset       = 1'b0;
        i_in_valid  = 1'b0;
        i_out_ready = 1'b0;
        i_ieee_a    = '0;
        i_ieee_b    = '0;
        #12;
        chk("rst_in_ready",  32'(o_in_ready), 32'd1);
        chk("rst_out_valid", 32'(o_out_valid), 32'd0);
        check_pair("rst", 32'h0, 32'h0, EXACT, EXACT);
        @(negedge clock_100Khz);
        reset = 1'b1;

        start_pair(32'h3F800000, 32'hC0000000);
        chk("norm_busy", 32'(o_in_ready), 32'd0);
        wait_out("norm", 4);
        check_pair("norm", 32'h3FE00000, 32'hC0000000, EXACT, EXACT);
        accept("norm");

        start_pair(32'h3F800003, 32'h3F800002);
        wait_out("rnd", 4);
        check_pair("rnd", 32'h3FE00001, 32'h3FE00000, INEXACT, INEXACT);
        accept("rnd");

        start_pair(32'h3FFFFFFF, 32'h40400000);
        wait_out("carry", 4);
        check_pair("carry", 32'h40000000, 32'h40100000, INEXACT, EXACT);
        accept("carry");

        start_pair(32'h00000001, 32'h80000000);
        wait_out("sub", 27);
        check_pair("sub", 32'h2D400000, 32'h80000000, EXACT, EXACT);
        accept("sub");

        start_pair(32'h7F800000, 32'hFFC00000);
        wait_out("spec", 2);
        check_pair("spec", 32'h7FE00000, 32'hFFF00000, OVERFLOW, OVERFLOW);
        accept("spec");

        // One-shift subnormal, then hold the result under backpressure with stray input pulses.
        start_pair(32'h3F800000, 32'h00400000);
        wait_out("bp", 6);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock_100Khz);
            i_in_valid = i[0];
            i_ieee_a   = 32'h40400000;
            i_ieee_b   = 32'h7F800000;
            @(posedge clock_100Khz);
            #1;
            chk("bp_in_ready", 32'(o_in_ready), 32'd0);
            chk("bp_valid", 32'(o_out_valid), 32'd1);
            chk("bp_op_a", o_op_a_out, 32'h3FE00000);
            chk("bp_op_b", o_op_b_out, 32'h30000000);
        end
        i_in_valid = 1'b0;
        chk("bp_st_b", 32'(o_status_b), 32'(EXACT));
        accept("bp");

        // Put a known non-zero result on the outputs, then reset in the middle of normalisation.
        start_pair(32'h7F800000, 32'hFFC00000);
        wait_out("pre_rst", 2);
        accept("pre_rst");
        start_pair(32'h00000001, 32'h3F800000);
        repeat (5) @(posedge clock_100Khz);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_valid", 32'(o_out_valid), 32'd0);
        check_pair("midrst", 32'h0, 32'h0, EXACT, EXACT);
        @(negedge clock_100Khz);
        reset = 1'b1;
        @(posedge clock_100Khz);
        #1;
        chk("postrst_in_ready", 32'(o_in_ready), 32'd1);
        chk("postrst_valid", 32'(o_out_valid), 32'd0);

        start_pair(32'h3F800000, 32'hC0000000);
        wait_out("recover", 4);
        check_pair("recover", 32'h3FE00000, 32'hC0000000, EXACT, EXACT);
        accept("recover");

        $display("%0d/%0d checks passed", npass, total);
        $finish;
    end

endmodule
